// File: rtl/md_seq_pkg.sv
// Shared encodings and helpers for the MUL/DIV sequencing controller.
package md_seq_pkg;

   localparam int unsigned MD_ST_W = 3;

   localparam logic [MD_ST_W-1:0] MD_ST_IDLE     = 3'd0;
   localparam logic [MD_ST_W-1:0] MD_ST_MUL      = 3'd1;
   localparam logic [MD_ST_W-1:0] MD_ST_DIV_INIT = 3'd2;
   localparam logic [MD_ST_W-1:0] MD_ST_DIV_ITER = 3'd3;
   localparam logic [MD_ST_W-1:0] MD_ST_DIV_LAST = 3'd4;
   localparam logic [MD_ST_W-1:0] MD_ST_DONE     = 3'd5;

   typedef enum logic [MD_ST_W-1:0] {
      ST_IDLE     = MD_ST_IDLE,
      ST_MUL      = MD_ST_MUL,
      ST_DIV_INIT = MD_ST_DIV_INIT,
      ST_DIV_ITER = MD_ST_DIV_ITER,
      ST_DIV_LAST = MD_ST_DIV_LAST,
      ST_DONE     = MD_ST_DONE
   } md_state_e;

   // Positions of the M-extension groups inside the decoded alu_op vector
   localparam int unsigned MD_ALU_OP_W = 21;
   localparam int unsigned MD_OP_MUL   = 10;
   localparam int unsigned MD_OP_DIV   = 14;
   localparam int unsigned MD_OP_N     = 4;

   // Ceiling log2, never below 1 so counters always have a real bit
   function automatic int unsigned md_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r = r + 1;
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/md_step_counter.sv
// Step counter with clear/increment and a terminal-count compare.
module md_step_counter
   import md_seq_pkg::*;
#(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] term_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (inc_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/md_seq_ctrl.sv
// Multi-cycle MUL/DIV sequencer driving EXE control pulses and the ID stall.
// Optional divide-by-zero fast path: MD_DIV_ZERO_FASTPATH_EN.
module md_seq_ctrl
   import md_seq_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 18,
   parameter int unsigned CNT_W      =
      md_clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush_i,
   input  logic             enable_i,
   input  logic             issue_valid_i,
   input  logic             is_mul_i,
   input  logic             is_div_i,
   input  logic [4:0]       rd_idx_i,
   input  logic [XLEN-1:0]  divisor_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] mul_state_o,
   output logic             d_init_o,
   output logic             d_advance_o,
   output logic             div_last_o,
   output logic             fin_o,
   output logic [4:0]       rd_idx_o,
   output logic             div_zero_o
);

   md_state_e        state_q, state_d;
   logic             accept_c;
   logic             fast_c;
   logic             cnt_inc_c;
   logic             cnt_clear_c;
   logic             tc_c;
   logic [CNT_W-1:0] term_c;
   logic [CNT_W-1:0] cnt;

   logic             stall_q;
   logic             busy_q;
   logic             mul_q;
   logic             d_init_q;
   logic             d_adv_q;
   logic             div_last_q;
   logic             fin_q;
   logic             div_zero_q;
   logic [4:0]       rd_idx_q;

   assign accept_c = (state_q == ST_IDLE) && issue_valid_i && (is_mul_i | is_div_i) && !flush_i;

`ifdef MD_DIV_ZERO_FASTPATH_EN
   assign fast_c = accept_c && is_div_i && (divisor_i == '0);
`else
   logic unused_divisor;
   assign unused_divisor = ^divisor_i;
   assign fast_c         = 1'b0;
`endif

   // Shared counter: MUL steps in MUL, iteration count in DIV_ITER
   md_step_counter #(
      .CNT_W (CNT_W)
   ) u_step_counter (
      .clk     (clk),
      .resetn  (resetn),
      .clear_i (cnt_clear_c),
      .inc_i   (cnt_inc_c),
      .term_i  (term_c),
      .cnt_o   (cnt),
      .tc_o    (tc_c)
   );

   // Next-state and counter control
   always_comb begin
      state_d   = state_q;
      cnt_inc_c = 1'b0;
      term_c    = CNT_W'(DIV_CYCLES - 3);
      if (state_q == ST_MUL)
         term_c = CNT_W'(MUL_CYCLES - 1);

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (fast_c)
                  state_d = ST_DONE;
               else if (is_div_i)
                  state_d = ST_DIV_INIT;
               else
                  state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            if (tc_c)
               state_d = ST_DONE;
            else
               cnt_inc_c = 1'b1;
         end
         ST_DIV_INIT: state_d = ST_DIV_ITER;
         ST_DIV_ITER: begin
            if (tc_c)
               state_d = ST_DIV_LAST;
            else
               cnt_inc_c = 1'b1;
         end
         ST_DIV_LAST: state_d = ST_DONE;
         ST_DONE: begin
            if (enable_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush_i) begin
         state_d   = ST_IDLE;
         cnt_inc_c = 1'b0;
      end
      cnt_clear_c = !cnt_inc_c;
   end

   // State register with outputs registered from the next state
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         stall_q    <= 1'b0;
         busy_q     <= 1'b0;
         mul_q      <= 1'b0;
         d_init_q   <= 1'b0;
         d_adv_q    <= 1'b0;
         div_last_q <= 1'b0;
         fin_q      <= 1'b0;
         div_zero_q <= 1'b0;
         rd_idx_q   <= 5'd0;
      end else begin
         state_q    <= state_d;
         stall_q    <= state_d inside {ST_MUL, ST_DIV_INIT, ST_DIV_ITER, ST_DIV_LAST};
         busy_q     <= (state_d != ST_IDLE);
         mul_q      <= (state_d == ST_MUL);
         d_init_q   <= (state_d == ST_DIV_INIT);
         d_adv_q    <= (state_d == ST_DIV_ITER) || (state_d == ST_DIV_LAST);
         div_last_q <= (state_d == ST_DIV_LAST);
         fin_q      <= (state_d == ST_DONE);
         div_zero_q <= (state_d == ST_DONE) && (fast_c || div_zero_q);
         if (flush_i)
            rd_idx_q <= 5'd0;
         else if (accept_c)
            rd_idx_q <= rd_idx_i;
      end
   end

   assign stall_o     = accept_c | stall_q;
   assign busy_o      = busy_q;
   assign mul_state_o = mul_q ? cnt : '0;
   assign d_init_o    = d_init_q;
   assign d_advance_o = d_adv_q;
   assign div_last_o  = div_last_q;
   assign fin_o       = fin_q;
   assign rd_idx_o    = rd_idx_q;
   assign div_zero_o  = div_zero_q;

endmodule
